// File: rtl/frame_sync_ctrl.sv
// Frame-boundary controller: shadows display updates and commits them on vsync,
// sequences the "DRINK!" blink and flags stale data. Option: FRAME_SYNC_VSYNC_SYNC_EN.
module frame_sync_ctrl #(
   parameter int unsigned BLINK_ON     = 30,
   parameter int unsigned BLINK_OFF    = 30,
   parameter int unsigned STALE_FRAMES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [3:0]  upd_level,
   input  logic [15:0] upd_time,
   input  logic [7:0]  upd_total,
   input  logic        remind,
   output logic [3:0]  act_level,
   output logic [15:0] act_time,
   output logic [7:0]  act_total,
   output logic        text_on,
   output logic        frame_start,
   output logic        stale
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_OFF
   } blink_state_e;

   localparam logic [7:0] ON_LAST   = 8'(BLINK_ON - 1);
   localparam logic [7:0] OFF_LAST  = 8'(BLINK_OFF - 1);
   localparam logic [7:0] STALE_MAX = 8'(STALE_FRAMES);

   logic         vsync_s;
   logic         vs_prev_q, vs_prev_d;
   logic         fall;
   logic         frame_start_q, frame_start_d;

   logic         pending_q, pending_d;
   logic [3:0]   pend_level_q, pend_level_d;
   logic [15:0]  pend_time_q, pend_time_d;
   logic [7:0]   pend_total_q, pend_total_d;
   logic [3:0]   act_level_q, act_level_d;
   logic [15:0]  act_time_q, act_time_d;
   logic [7:0]   act_total_q, act_total_d;
   logic [7:0]   stale_cnt_q, stale_cnt_d;

   blink_state_e state_q, state_d;
   logic [7:0]   bc_q, bc_d;

   logic         accept;
   logic         commit;

`ifdef FRAME_SYNC_VSYNC_SYNC_EN
   logic sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = vsync;
      sync2_d = sync1_q;
      vsync_s = sync2_q;
   end

   // Synchronizer flops reset high so a low vsync at reset release is not a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end
`else
   always_comb begin
      vsync_s = vsync;
   end
`endif

   always_comb begin
      vs_prev_d     = vsync_s;
      fall          = vs_prev_q & ~vsync_s;
      frame_start_d = fall;
   end

   // Pending data wins over a simultaneous offer: ready is low while anything is held.
   always_comb begin
      pending_d    = pending_q;
      pend_level_d = pend_level_q;
      pend_time_d  = pend_time_q;
      pend_total_d = pend_total_q;
      act_level_d  = act_level_q;
      act_time_d   = act_time_q;
      act_total_d  = act_total_q;
      stale_cnt_d  = stale_cnt_q;

      accept = upd_valid & ~pending_q;
      commit = fall & pending_q;

      if (commit) begin
         act_level_d = pend_level_q;
         act_time_d  = pend_time_q;
         act_total_d = pend_total_q;
         pending_d   = 1'b0;
         stale_cnt_d = 8'd0;
      end else if (fall && (stale_cnt_q < STALE_MAX)) begin
         stale_cnt_d = stale_cnt_q + 8'd1;
      end

      if (accept) begin
         pend_level_d = upd_level;
         pend_time_d  = upd_time;
         pend_total_d = upd_total;
         pending_d    = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      bc_d    = bc_q;
      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (remind) begin
                  state_d = ST_ON;
                  bc_d    = 8'd0;
               end
            end
            ST_ON: begin
               if (!remind) begin
                  state_d = ST_IDLE;
                  bc_d    = 8'd0;
               end else if (bc_q == ON_LAST) begin
                  state_d = ST_OFF;
                  bc_d    = 8'd0;
               end else begin
                  bc_d = bc_q + 8'd1;
               end
            end
            ST_OFF: begin
               if (!remind) begin
                  state_d = ST_IDLE;
                  bc_d    = 8'd0;
               end else if (bc_q == OFF_LAST) begin
                  state_d = ST_ON;
                  bc_d    = 8'd0;
               end else begin
                  bc_d = bc_q + 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               bc_d    = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_prev_q     <= 1'b1;
         frame_start_q <= 1'b0;
         pending_q     <= 1'b0;
         pend_level_q  <= 4'd0;
         pend_time_q   <= 16'd0;
         pend_total_q  <= 8'd0;
         act_level_q   <= 4'd0;
         act_time_q    <= 16'd0;
         act_total_q   <= 8'd0;
         stale_cnt_q   <= 8'd0;
         state_q       <= ST_IDLE;
         bc_q          <= 8'd0;
      end else begin
         vs_prev_q     <= vs_prev_d;
         frame_start_q <= frame_start_d;
         pending_q     <= pending_d;
         pend_level_q  <= pend_level_d;
         pend_time_q   <= pend_time_d;
         pend_total_q  <= pend_total_d;
         act_level_q   <= act_level_d;
         act_time_q    <= act_time_d;
         act_total_q   <= act_total_d;
         stale_cnt_q   <= stale_cnt_d;
         state_q       <= state_d;
         bc_q          <= bc_d;
      end
   end

   always_comb begin
      upd_ready   = ~pending_q;
      act_level   = act_level_q;
      act_time    = act_time_q;
      act_total   = act_total_q;
      text_on     = (state_q == ST_ON);
      frame_start = frame_start_q;
      stale       = (stale_cnt_q == STALE_MAX);
   end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Randomized and directed bench for frame_sync_ctrl against a frame-level reference model.
module tb_frame_sync_ctrl;

   localparam int T_ON    = 2;
   localparam int T_OFF   = 3;
   localparam int T_STALE = 4;
`ifdef FRAME_SYNC_VSYNC_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic        clk;
   logic        reset;
   logic        vsync;
   logic        upd_valid;
   logic        upd_ready;
   logic [3:0]  upd_level;
   logic [15:0] upd_time;
   logic [7:0]  upd_total;
   logic        remind;
   logic [3:0]  act_level;
   logic [15:0] act_time;
   logic [7:0]  act_total;
   logic        text_on;
   logic        frame_start;
   logic        stale;

   frame_sync_ctrl #(
      .BLINK_ON(T_ON),
      .BLINK_OFF(T_OFF),
      .STALE_FRAMES(T_STALE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .vsync(vsync),
      .upd_valid(upd_valid),
      .upd_ready(upd_ready),
      .upd_level(upd_level),
      .upd_time(upd_time),
      .upd_total(upd_total),
      .remind(remind),
      .act_level(act_level),
      .act_time(act_time),
      .act_total(act_total),
      .text_on(text_on),
      .frame_start(frame_start),
      .stale(stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state, kept at frame granularity
   bit [3:0]  m_hist;
   bit        m_pending;
   bit [3:0]  m_p_level;
   bit [15:0] m_p_time;
   bit [7:0]  m_p_total;
   bit [3:0]  m_level;
   bit [15:0] m_time;
   bit [7:0]  m_total;
   int        m_frames_since_commit;
   bit        m_blinking;
   int        m_blink_frames;
   bit        m_fs;

   // Captured at the frame_start cycle of doFrame
   bit        cap_seen;
   bit        cap_text;
   bit        cap_stale;
   bit        cap_ready;
   bit [3:0]  cap_level;
   bit [15:0] cap_time;
   bit [7:0]  cap_total;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelStep();
      bit fall;
      bit was_pending;
      if (reset) begin
         m_hist = 4'b1111;
         m_pending = 0;
         m_p_level = 0; m_p_time = 0; m_p_total = 0;
         m_level = 0; m_time = 0; m_total = 0;
         m_frames_since_commit = 0;
         m_blinking = 0;
         m_blink_frames = 0;
         m_fs = 0;
      end else begin
         m_hist = {m_hist[2:0], vsync};
         fall = (m_hist[D] == 1'b0) && (m_hist[D+1] == 1'b1);
         m_fs = fall;
         was_pending = m_pending;
         if (fall) begin
            if (was_pending) begin
               m_level = m_p_level; m_time = m_p_time; m_total = m_p_total;
               m_pending = 0;
               m_frames_since_commit = 0;
            end else if (m_frames_since_commit < T_STALE) begin
               m_frames_since_commit++;
            end
            if (!remind) begin
               m_blinking = 0;
            end else if (!m_blinking) begin
               m_blinking = 1;
               m_blink_frames = 0;
            end else begin
               m_blink_frames++;
            end
         end
         if (upd_valid && !was_pending) begin
            m_p_level = upd_level; m_p_time = upd_time; m_p_total = upd_total;
            m_pending = 1;
         end
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic vs, input logic valid,
                                input logic [3:0] lvl, input logic [15:0] tm,
                                input logic [7:0] tot, input logic rem);
      bit exp_text;
      reset = rst; vsync = vs; upd_valid = valid;
      upd_level = lvl; upd_time = tm; upd_total = tot; remind = rem;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      exp_text = m_blinking && ((m_blink_frames % (T_ON + T_OFF)) < T_ON);
      checkOutput("upd_ready", 32'(upd_ready), 32'(!m_pending));
      checkOutput("act_level", 32'(act_level), 32'(m_level));
      checkOutput("act_time", 32'(act_time), 32'(m_time));
      checkOutput("act_total", 32'(act_total), 32'(m_total));
      checkOutput("text_on", 32'(text_on), 32'(exp_text));
      checkOutput("frame_start", 32'(frame_start), 32'(m_fs));
      checkOutput("stale", 32'(stale), 32'(m_frames_since_commit >= T_STALE));
   endtask

   // One vsync low pulse then high; records outputs at the frame_start cycle
   task automatic doFrame(input logic valid, input logic [3:0] lvl, input logic rem);
      cap_seen = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, (i < 4) ? 1'b0 : 1'b1, valid, lvl, 16'h0, 8'h0, rem);
         if (frame_start === 1'b1) begin
            cap_seen  = 1;
            cap_text  = text_on;
            cap_stale = stale;
            cap_ready = upd_ready;
            cap_level = act_level;
            cap_time  = act_time;
            cap_total = act_total;
         end
      end
      checkOutput("frame_seen", 32'(cap_seen), 32'd1);
   endtask

   task automatic doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 16'h0, 8'h0, 1'b0);
   endtask

   initial begin
      bit exp_blink [7];
      bit vs_lvl;
      int vs_left;
      int vp;
      bit rem;

      exp_blink = '{1, 1, 0, 0, 0, 1, 1};
      reset = 1; vsync = 1; upd_valid = 0; upd_level = 0;
      upd_time = 0; upd_total = 0; remind = 0;
      @(negedge clk);

      $display("[TB] reset and idle");
      doReset();
      for (int i = 0; i < 100; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 8'h0, 1'b0);

      $display("[TB] single update");
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd9, 16'h1234, 8'h27, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, 16'h9999, 8'h55, 1'b0);
      checkOutput("ready_after_accept", 32'(upd_ready), 32'd0);
      doFrame(1'b0, 4'd0, 1'b0);
      checkOutput("commit_level", 32'(cap_level), 32'd9);
      checkOutput("commit_time", 32'(cap_time), 32'h1234);
      checkOutput("commit_total", 32'(cap_total), 32'h27);
      checkOutput("commit_ready", 32'(cap_ready), 32'd1);

      $display("[TB] back-pressure");
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 16'h0, 8'h0, 1'b0);
      doFrame(1'b1, 4'd5, 1'b0);
      checkOutput("bp_first_level", 32'(cap_level), 32'd3);
      doFrame(1'b0, 4'd0, 1'b0);
      checkOutput("bp_second_level", 32'(cap_level), 32'd5);

      $display("[TB] blink and stale");
      doReset();
      for (int f = 0; f < 7; f++) begin
         doFrame(1'b0, 4'd0, 1'b1);
         checkOutput($sformatf("blink_f%0d", f + 1), 32'(cap_text), 32'(exp_blink[f]));
         if (f == 2) checkOutput("stale_f3", 32'(cap_stale), 32'd0);
         if (f >= 3) checkOutput("stale_hold", 32'(cap_stale), 32'd1);
      end
      doFrame(1'b0, 4'd0, 1'b0);
      checkOutput("blink_drop", 32'(cap_text), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, 16'h0042, 8'h10, 1'b0);
      doFrame(1'b0, 4'd0, 1'b0);
      checkOutput("stale_cleared", 32'(cap_stale), 32'd0);

      $display("[TB] reset mid-operation");
      doFrame(1'b0, 4'd0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd6, 16'h0777, 8'h33, 1'b1);
      doReset();
      doFrame(1'b0, 4'd0, 1'b0);
      checkOutput("rst_no_commit", 32'(cap_level), 32'd0);

      $display("[TB] randomized traffic");
      vs_lvl = 1; vs_left = 5; vp = 2; rem = 0;
      for (int c = 0; c < 4000; c++) begin
         if (vs_left == 0) begin
            vs_lvl  = ~vs_lvl;
            vs_left = vs_lvl ? $urandom_range(4, 14) : $urandom_range(1, 5);
         end
         vs_left--;
         if (c % 500 == 0) vp = $urandom_range(0, 7);
         if ($urandom_range(0, 39) == 0) rem = ~rem;
         applyStimulus(($urandom_range(0, 599) == 0), vs_lvl,
                       ($urandom_range(0, 7) < vp),
                       4'($urandom), 16'($urandom), 8'($urandom), rem);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
